// File: rtl/decoder_pkg.sv
// Shared types and the select-decode function for decoder_stream.
package decoder_pkg;

  typedef enum logic {DEC_ONEHOT, DEC_THERMO} dec_mode_e;

  // Widest decoded word the helper can produce; callers slice the low NOUT bits.
  localparam int unsigned MaxNout = 64;

  function automatic logic [MaxNout-1:0] dec_word(input logic [31:0]   sel,
                                                  input logic          en,
                                                  input dec_mode_e     mode,
                                                  input int unsigned   nout);
    logic [MaxNout-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < MaxNout; k++) begin
      if (en && (sel < nout) && (k < nout)) begin
        if (mode == DEC_ONEHOT) w[k] = (k == sel);
        else                    w[k] = (k <= sel);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-slot valid/ready skid buffer: output register plus one skid slot, full throughput,
// in_ready driven purely from registered state.
module skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         live_q;
  logic         in_fire, out_fire;

  // live_q keeps in_ready low until the first edge after reset is released.
  assign in_ready  = live_q & ~(out_valid_q & skid_valid_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_fire) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      live_q       <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      live_q       <= 1'b1;
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Pipelined select decoder (one-hot or thermometer) with out-of-range flag,
// streamed through a two-slot skid buffer.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned NOUT  = 2 ** SEL_W,
  parameter dec_mode_e   MODE  = DEC_ONEHOT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NOUT-1:0]  out_word,
  output logic             out_err
);

  logic [31:0]        sel_ext;
  logic               err;
  logic [MaxNout-1:0] full_word;
  logic [NOUT:0]      in_data;
  logic [NOUT:0]      out_data;

  assign sel_ext   = 32'(in_sel);
  assign err       = (sel_ext >= NOUT);
  assign full_word = dec_word(sel_ext, in_en, MODE, NOUT);
  assign in_data   = {err, full_word[NOUT-1:0]};

  if (NOUT < MaxNout) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^full_word[MaxNout-1:NOUT];
  end

  skid_buf #(
    .W (NOUT + 1)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_word = out_data[NOUT-1:0];
  assign out_err  = out_data[NOUT];

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: directed vectors, stall/reset sequences and randomized
// throttled traffic against a queue-based reference model, on a one-hot and a thermo instance.
module tb_decoder_stream;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_in_en = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic [1:0] a_in_sel = '0;
  logic [3:0] a_out_word;
  logic       a_out_err;

  logic       b_in_valid = 1'b0, b_in_ready, b_in_en = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic [2:0] b_in_sel = '0;
  logic [5:0] b_out_word;
  logic       b_out_err;

  decoder_stream #(.SEL_W(2), .NOUT(4), .MODE(DEC_ONEHOT)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_en(a_in_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_word(a_out_word), .out_err(a_out_err)
  );

  decoder_stream #(.SEL_W(3), .NOUT(6), .MODE(DEC_THERMO)) u_dut_b (
    .clk(clk), .reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_en(b_in_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_word(b_out_word), .out_err(b_out_err)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] word;
  } exp_t;

  typedef struct {
    bit         use_b;
    logic [2:0] sel;
    logic       en;
    logic [7:0] exp_word;
    logic       exp_err;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   a_acc    = 0;
  int   b_acc    = 0;
  bit   live     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode straight from the arithmetic meaning of one-hot / thermometer.
  function automatic exp_t ref_dec(int unsigned sel, bit en, bit thermo, int unsigned nout);
    exp_t e;
    e.err  = (sel >= nout);
    e.word = '0;
    if (en && !e.err) e.word = thermo ? 8'((2 << sel) - 1) : 8'(1 << sel);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Scoreboard: outputs must present the head of the pending queue; ready iff fewer than 2 pending.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      check("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      if (qa.size() > 0) begin
        check("a_out_word", 64'(a_out_word), 64'(qa[0].word));
        check("a_out_err", 64'(a_out_err), 64'(qa[0].err));
      end
      check("a_in_ready", 64'(a_in_ready), 64'(live && qa.size() < 2));
      if (a_out_valid && a_out_ready && qa.size() > 0) void'(qa.pop_front());
      if (a_in_valid && a_in_ready) begin
        qa.push_back(ref_dec(32'(a_in_sel), a_in_en, 1'b0, 4));
        a_acc++;
      end

      check("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      if (qb.size() > 0) begin
        check("b_out_word", 64'(b_out_word), 64'(qb[0].word));
        check("b_out_err", 64'(b_out_err), 64'(qb[0].err));
      end
      check("b_in_ready", 64'(b_in_ready), 64'(live && qb.size() < 2));
      if (b_out_valid && b_out_ready && qb.size() > 0) void'(qb.pop_front());
      if (b_in_valid && b_in_ready) begin
        qb.push_back(ref_dec(32'(b_in_sel), b_in_en, 1'b1, 6));
        b_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];
  int   cyc;
  int   a0, b0;

  initial begin
    vecs[0] = '{1'b0, 3'd0, 1'b1, 8'h01, 1'b0};
    vecs[1] = '{1'b0, 3'd1, 1'b1, 8'h02, 1'b0};
    vecs[2] = '{1'b0, 3'd2, 1'b1, 8'h04, 1'b0};
    vecs[3] = '{1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
    vecs[4] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 1'b1, 8'h0f, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 3'd5, 1'b1, 8'h3f, 1'b0};
    vecs[8] = '{1'b1, 3'd6, 1'b0, 8'h00, 1'b1};

    // Reset state
    #2;
    check("rst_a_valid", 64'(a_out_valid), 64'(0));
    check("rst_a_word", 64'(a_out_word), 64'(0));
    check("rst_a_err", 64'(a_out_err), 64'(0));
    check("rst_a_ready", 64'(a_in_ready), 64'(0));
    check("rst_b_valid", 64'(b_out_valid), 64'(0));
    check("rst_b_ready", 64'(b_in_ready), 64'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst_hold_ready", 64'(a_in_ready), 64'(0));
    step();
    check("first_edge_a_ready", 64'(a_in_ready), 64'(1));
    check("first_edge_b_ready", 64'(b_in_ready), 64'(1));

    // Directed vectors, back-to-back, 1-cycle latency
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) begin
        if (vecs[i-1].use_b) begin
          check($sformatf("vec%0d_valid", i-1), 64'(b_out_valid), 64'(1));
          check($sformatf("vec%0d_word", i-1), 64'(b_out_word), 64'(vecs[i-1].exp_word));
          check($sformatf("vec%0d_err", i-1), 64'(b_out_err), 64'(vecs[i-1].exp_err));
          check($sformatf("vec%0d_ready", i-1), 64'(b_in_ready), 64'(1));
        end else begin
          check($sformatf("vec%0d_valid", i-1), 64'(a_out_valid), 64'(1));
          check($sformatf("vec%0d_word", i-1), 64'(a_out_word), 64'(vecs[i-1].exp_word));
          check($sformatf("vec%0d_err", i-1), 64'(a_out_err), 64'(vecs[i-1].exp_err));
          check($sformatf("vec%0d_ready", i-1), 64'(a_in_ready), 64'(1));
        end
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      if (i < 9) begin
        if (vecs[i].use_b) begin
          b_in_valid = 1'b1; b_in_sel = vecs[i].sel; b_in_en = vecs[i].en;
        end else begin
          a_in_valid = 1'b1; a_in_sel = vecs[i].sel[1:0]; a_in_en = vecs[i].en;
        end
      end
      step();
    end
    check("single_cycle_a", 64'(a_out_valid), 64'(0));
    check("single_cycle_b", 64'(b_out_valid), 64'(0));

    // Stall: out_ready low for 4 cycles with sel=1,2,3 offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_en = 1'b1; a_in_sel = 2'd1;
    step();
    check("stall_acc1_word", 64'(a_out_word), 64'(4'b0010));
    check("stall_acc1_ready", 64'(a_in_ready), 64'(1));
    a_in_sel = 2'd2;
    step();
    check("stall_full_ready", 64'(a_in_ready), 64'(0));
    check("stall_full_word", 64'(a_out_word), 64'(4'b0010));
    a_in_sel = 2'd3;
    step();
    check("stall_hold1_word", 64'(a_out_word), 64'(4'b0010));
    check("stall_hold1_ready", 64'(a_in_ready), 64'(0));
    step();
    check("stall_hold2_word", 64'(a_out_word), 64'(4'b0010));
    a_out_ready = 1'b1;
    step();
    check("release_word2", 64'(a_out_word), 64'(4'b0100));
    check("release_ready", 64'(a_in_ready), 64'(1));
    step();
    check("release_word3", 64'(a_out_word), 64'(4'b1000));
    a_in_valid = 1'b0;
    step();
    check("release_drained", 64'(a_out_valid), 64'(0));

    // Reset with both slots full
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd1;
    step();
    a_in_sel = 2'd2;
    step();
    check("prereset_full", 64'(a_in_ready), 64'(0));
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(a_out_valid), 64'(0));
    check("async_rst_word", 64'(a_out_word), 64'(0));
    check("async_rst_ready", 64'(a_in_ready), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(a_in_ready), 64'(1));
    a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_en = 1'b1; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("post_rst_valid", 64'(a_out_valid), 64'(1));
    check("post_rst_word", 64'(a_out_word), 64'(4'b1000));
    step();

    // Randomized throttled traffic on both instances
    cyc = 0;
    a0  = a_acc;
    b0  = b_acc;
    while ((a_acc - a0 < 10000 || b_acc - b0 < 10000) && cyc < 60000) begin
      a_in_valid  = ($urandom_range(3) != 0);
      a_in_sel    = 2'($urandom);
      a_in_en     = ($urandom_range(3) != 0);
      a_out_ready = ($urandom_range(3) != 0);
      b_in_valid  = ($urandom_range(3) != 0);
      b_in_sel    = 3'($urandom);
      b_in_en     = ($urandom_range(3) != 0);
      b_out_ready = ($urandom_range(3) != 0);
      step();
      cyc++;
    end
    check("rand_a_count", 64'(a_acc - a0 >= 10000), 64'(1));
    check("rand_b_count", 64'(b_acc - b0 >= 10000), 64'(1));

    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (4) step();
    check("drain_a", 64'(a_out_valid), 64'(0));
    check("drain_b", 64'(b_out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
